// File: rtl/minirisc_pkg.sv
// Shared types and constants for the minirisc instruction streamer.
package minirisc_pkg;

    // Issue sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } issue_state_t;

    // One program word: [15:8] goes to the core's ui_in, [7:0] to its uio_in.
    typedef logic [15:0] instr_word_t;

    // Word driven on the bus whenever no instruction is valid.
    localparam instr_word_t NOP_DEFAULT = 16'h0000;

    // Byte lanes of a program word as seen by the core.
    function automatic logic [7:0] word_hi(input instr_word_t w);
        return w[15:8];
    endfunction

    function automatic logic [7:0] word_lo(input instr_word_t w);
        return w[7:0];
    endfunction

endpackage

// File: rtl/minirisc_prog_ram.sv
// Program buffer: DEPTH x 16-bit storage with synchronous write and a
// registered read port. A read and write to the same address on the same
// edge returns the old word. When no read is requested the read register
// loads the NOP word, so it can drive the core bus directly.
module minirisc_prog_ram
    import minirisc_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter instr_word_t NOP_WORD = NOP_DEFAULT,
    localparam int         AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  instr_word_t   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output instr_word_t   rd_data
);

    instr_word_t mem [DEPTH];

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; shows NOP whenever no word is being issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= NOP_WORD;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= NOP_WORD;
        end
    end

endmodule

// File: rtl/minirisc_instr_streamer.sv
// Instruction streamer for the tt_um_minirisc core. Holds a small program
// buffer and, on start, issues one word per slot onto ui_out/uio_out with
// ISSUE_GAP idle cycles after each word, looping or stopping at the end.
// Optional build macro MINIRISC_STREAMER_CHECKSUM_EN adds an 8-bit XOR
// checksum of result_in taken on every valid issue cycle.
module minirisc_instr_streamer
    import minirisc_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter int          ISSUE_GAP = 0,
    parameter instr_word_t NOP_WORD  = NOP_DEFAULT,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [AW:0]   prog_len,
    input  logic [7:0]    result_in,
    output logic [7:0]    ui_out,
    output logic [7:0]    uio_out,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
`ifdef MINIRISC_STREAMER_CHECKSUM_EN
    ,
    output logic [7:0]    checksum
`endif
);

    // Gap counter preload: counts GAP cycles down to zero.
    localparam logic [3:0]  GAP_INIT  = 4'(ISSUE_GAP - 1);
    localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

    issue_state_t  state, state_nxt;
    logic [AW-1:0] pc_nxt;
    logic [AW:0]   len_q, len_nxt;
    logic [AW:0]   last_idx;
    logic [AW:0]   len_clamped;
    logic [3:0]    gap_cnt, gap_nxt;
    logic          at_end;
    logic          advance;
    logic          done_nxt;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    instr_word_t   rd_word;

    assign len_clamped = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
    assign last_idx    = len_q - (AW+1)'(1);
    assign at_end      = ({1'b0, pc} == last_idx);

    minirisc_prog_ram #(
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP_WORD)
    ) u_prog_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    // The RAM read register is the bus output register.
    assign ui_out  = word_hi(rd_word);
    assign uio_out = word_lo(rd_word);

    // Next-state logic: accept, issue, gap countdown and end-of-program advance.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        len_nxt   = len_q;
        gap_nxt   = gap_cnt;
        done_nxt  = 1'b0;
        advance   = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;

        case (state)
            IDLE: begin
                // stop has priority over start; an empty program is ignored.
                if (start && !stop && (prog_len != '0)) begin
                    state_nxt = ISSUE;
                    pc_nxt    = '0;
                    len_nxt   = len_clamped;
                end
            end
            ISSUE: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (ISSUE_GAP == 0) begin
                    advance = 1'b1;
                end else begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_INIT;
                end
            end
            GAP: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (gap_cnt != '0) begin
                    gap_nxt = gap_cnt - 4'd1;
                end else begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Step past the word at pc; loop_en is looked at only here.
        if (advance) begin
            if (!at_end) begin
                state_nxt = ISSUE;
                pc_nxt    = pc + AW'(1);
            end else if (loop_en) begin
                state_nxt = ISSUE;
                pc_nxt    = '0;
            end else begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
        end

        // The word to show next cycle is fetched on the same edge.
        rd_en   = (state_nxt == ISSUE);
        rd_addr = pc_nxt;
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            len_q       <= '0;
            gap_cnt     <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            len_q       <= len_nxt;
            gap_cnt     <= gap_nxt;
            instr_valid <= (state_nxt == ISSUE);
            busy        <= (state_nxt != IDLE);
            done        <= done_nxt;
        end
    end

`ifdef MINIRISC_STREAMER_CHECKSUM_EN
    logic start_accept;
    assign start_accept = (state == IDLE) && (state_nxt == ISSUE);

    // XOR-accumulate the core result on every valid issue cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= 8'h00;
        end else if (start_accept) begin
            checksum <= 8'h00;
        end else if (instr_valid) begin
            checksum <= checksum ^ result_in;
        end
    end
`else
    logic unused_result;
    assign unused_result = ^result_in;
`endif

endmodule

// File: tb/tb_minirisc_instr_streamer.sv
// Bench for minirisc_instr_streamer: two instances (ISSUE_GAP 0 and 2)
// share the write port and reset; each run is predicted as a list of
// per-cycle bus expectations built from the program contents.
module tb_minirisc_instr_streamer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int GAP_B = 2;
    localparam logic [15:0] NOP = 16'h0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [7:0]    result_in;
    logic          start_a, stop_a, loop_a, start_b, stop_b, loop_b;
    logic [AW:0]   len_a, len_b;
    logic [7:0]    ui_a, uio_a, ui_b, uio_b;
    logic          vld_a, vld_b, busy_a, busy_b, done_a, done_b;
    logic [AW-1:0] pc_a, pc_b;
    logic [7:0]    cs_a, cs_b;

    minirisc_instr_streamer #(.DEPTH(DEPTH), .ISSUE_GAP(0), .NOP_WORD(NOP)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start_a), .stop(stop_a), .loop_en(loop_a), .prog_len(len_a),
        .result_in(result_in), .ui_out(ui_a), .uio_out(uio_a), .instr_valid(vld_a),
        .pc(pc_a), .busy(busy_a), .done(done_a)
`ifdef MINIRISC_STREAMER_CHECKSUM_EN
        , .checksum(cs_a)
`endif
    );

    minirisc_instr_streamer #(.DEPTH(DEPTH), .ISSUE_GAP(GAP_B), .NOP_WORD(NOP)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start_b), .stop(stop_b), .loop_en(loop_b), .prog_len(len_b),
        .result_in(result_in), .ui_out(ui_b), .uio_out(uio_b), .instr_valid(vld_b),
        .pc(pc_b), .busy(busy_b), .done(done_b)
`ifdef MINIRISC_STREAMER_CHECKSUM_EN
        , .checksum(cs_b)
`endif
    );

`ifndef MINIRISC_STREAMER_CHECKSUM_EN
    assign cs_a = 8'h00;
    assign cs_b = 8'h00;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [15:0]   mdl_mem [DEPTH];
    logic [AW-1:0] mdl_pc  [2];
    logic [7:0]    mdl_cs  [2];

    typedef struct {
        logic          v;
        logic [15:0]   w;
        logic [AW-1:0] pc;
        logic          busy;
        logic          done;
        bit            do_stop;
        bit            do_wr;
    } item_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ctl(input int d, input logic st, input logic sp);
        if (d == 0) begin start_a = st; stop_a = sp; end
        else        begin start_b = st; stop_b = sp; end
    endtask

    task automatic check_dut(input int d, input string tag, input item_t it);
        if (d == 0) begin
            check({tag, " bus"},   {16'h0, ui_a, uio_a}, {16'h0, it.w});
            check({tag, " valid"}, {31'h0, vld_a},  {31'h0, it.v});
            check({tag, " pc"},    {29'h0, pc_a},   {29'h0, it.pc});
            check({tag, " busy"},  {31'h0, busy_a}, {31'h0, it.busy});
            check({tag, " done"},  {31'h0, done_a}, {31'h0, it.done});
        end else begin
            check({tag, " bus"},   {16'h0, ui_b, uio_b}, {16'h0, it.w});
            check({tag, " valid"}, {31'h0, vld_b},  {31'h0, it.v});
            check({tag, " pc"},    {29'h0, pc_b},   {29'h0, it.pc});
            check({tag, " busy"},  {31'h0, busy_b}, {31'h0, it.busy});
            check({tag, " done"},  {31'h0, done_b}, {31'h0, it.done});
        end
    endtask

    task automatic check_reset(input int d, input string tag);
        item_t it;
        it = '{v:1'b0, w:NOP, pc:'0, busy:1'b0, done:1'b0, do_stop:1'b0, do_wr:1'b0};
        check_dut(d, tag, it);
`ifdef MINIRISC_STREAMER_CHECKSUM_EN
        check({tag, " checksum"}, {24'h0, (d == 0) ? cs_a : cs_b}, 32'h0);
`endif
    endtask

    task automatic load(input int a, input logic [15:0] w);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = w;
        @(negedge clk);
        wr_en = 1'b0;
        mdl_mem[a] = w;
    endtask

    // One program run on DUT d. Called at a negedge with the DUT idle.
    // lp=1 issues nwords words; stop_k is the word index during which stop is
    // raised (-1 none); wr_item is the cycle index during which a write of
    // wdata to waddr is presented (-1 none).
    task automatic run(input int d, input int plen, input bit lp, input int nwords,
                       input int stop_k, input int wr_item, input int waddr,
                       input logic [15:0] wdata, input string name);
        item_t q[$];
        item_t it;
        int eff, gap, idx, nw, vcnt;
        bit wapplied, stopped, use_wr;
        logic [7:0] cs, rv;

        gap       = (d == 0) ? 0 : GAP_B;
        eff       = (plen > DEPTH) ? DEPTH : plen;
        nw        = lp ? nwords : eff;
        wapplied  = (wr_item < 0);
        stopped   = 1'b0;
        use_wr    = (wr_item >= 0);

        if (eff == 0) begin
            repeat (3) begin
                it = '{v:1'b0, w:NOP, pc:mdl_pc[d], busy:1'b0, done:1'b0, do_stop:1'b0, do_wr:1'b0};
                q.push_back(it);
            end
        end else begin
            for (int k = 0; k < nw; k++) begin
                idx = k % eff;
                // A word fetched two or more cycles after the write cycle sees new data.
                if (!wapplied && q.size() >= wr_item + 2) begin
                    mdl_mem[waddr] = wdata;
                    wapplied = 1'b1;
                end
                it = '{v:1'b1, w:mdl_mem[idx], pc:AW'(idx), busy:1'b1, done:1'b0,
                       do_stop:(k == stop_k), do_wr:1'b0};
                q.push_back(it);
                if (k == stop_k) begin
                    it = '{v:1'b0, w:NOP, pc:AW'(idx), busy:1'b0, done:1'b0, do_stop:1'b0, do_wr:1'b0};
                    q.push_back(it);
                    stopped = 1'b1;
                    break;
                end
                for (int g = 0; g < gap; g++) begin
                    it = '{v:1'b0, w:NOP, pc:AW'(idx), busy:1'b1, done:1'b0, do_stop:1'b0, do_wr:1'b0};
                    q.push_back(it);
                end
            end
            if (!stopped && !lp) begin
                it = '{v:1'b0, w:NOP, pc:AW'(eff - 1), busy:1'b0, done:1'b1, do_stop:1'b0, do_wr:1'b0};
                q.push_back(it);
                it.done = 1'b0;
                q.push_back(it);
            end
        end

        if (use_wr) begin
            if (wr_item < q.size()) begin
                q[wr_item].do_wr = 1'b1;
                if (!wapplied) mdl_mem[waddr] = wdata;
            end else begin
                use_wr = 1'b0;
            end
        end

        // Launch
        if (d == 0) begin len_a = (AW+1)'(plen); loop_a = lp; end
        else        begin len_b = (AW+1)'(plen); loop_b = lp; end
        set_ctl(d, 1'b1, 1'b0);
        @(negedge clk);

        cs   = (eff != 0) ? 8'h00 : mdl_cs[d];
        vcnt = 0;
        foreach (q[m]) begin
            check_dut(d, $sformatf("%s[%0d]", name, m), q[m]);
`ifdef MINIRISC_STREAMER_CHECKSUM_EN
            check($sformatf("%s[%0d] checksum", name, m), {24'h0, (d == 0) ? cs_a : cs_b}, {24'h0, cs});
`endif
            // start while busy must be ignored; stop beats start.
            set_ctl(d, q[m].busy && ($urandom_range(0, 2) == 0), q[m].do_stop);
            wr_en   = q[m].do_wr;
            wr_addr = AW'(waddr);
            wr_data = wdata;
            if (q[m].v) begin
                rv = 8'(((vcnt % 15) + 1) * 17);
                cs = cs ^ rv;
                vcnt++;
            end else begin
                rv = 8'($urandom);
            end
            result_in = rv;
            @(negedge clk);
            set_ctl(d, 1'b0, 1'b0);
            wr_en = 1'b0;
        end
        mdl_pc[d] = q[q.size() - 1].pc;
        mdl_cs[d] = cs;
    endtask

    initial begin
        int d, plen, nw, sk, wi;
        bit lp;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; result_in = '0;
        start_a = 1'b0; stop_a = 1'b0; loop_a = 1'b0; len_a = '0;
        start_b = 1'b0; stop_b = 1'b0; loop_b = 1'b0; len_b = '0;
        mdl_pc[0] = '0; mdl_pc[1] = '0; mdl_cs[0] = '0; mdl_cs[1] = '0;
        repeat (2) @(negedge clk);
        check_reset(0, "reset_a");
        check_reset(1, "reset_b");
        rst = 1'b0;

        load(0, 16'h0101); load(1, 16'h0202); load(2, 16'h0303); load(3, 16'h0404);
        for (int i = 4; i < DEPTH; i++) load(i, 16'($urandom));

        run(0, 4, 1'b0, 0, -1, -1, 0, 16'h0, "basic");
        run(0, 4, 1'b1, 7, 6, -1, 0, 16'h0, "loop_stop");
        run(1, 2, 1'b0, 0, -1, -1, 0, 16'h0, "gap2");
        run(0, 0, 1'b0, 0, -1, -1, 0, 16'h0, "len0_a");
        run(1, 0, 1'b0, 0, -1, -1, 0, 16'h0, "len0_b");
        run(0, 9, 1'b0, 0, -1, -1, 0, 16'h0, "clamp");
        run(1, 3, 1'b1, 5, 4, -1, 0, 16'h0, "gap_loop");
        run(0, 4, 1'b1, 7, 6, 1, 2, 16'hAAAA, "rbw");

        // Simultaneous start and stop while idle: stays idle.
        len_a = 4; loop_a = 1'b0; start_a = 1'b1; stop_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; stop_a = 1'b0;
        check("start_stop busy",  {31'h0, busy_a}, 32'h0);
        check("start_stop valid", {31'h0, vld_a},  32'h0);

        // Reset in the middle of a looping run.
        len_a = 8; loop_a = 1'b1; start_a = 1'b1;
        len_b = 8; loop_b = 1'b1; start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_run busy", {31'h0, busy_a}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check_reset(0, "midrst_a");
        check_reset(1, "midrst_b");
        rst = 1'b0;
        mdl_pc[0] = '0; mdl_pc[1] = '0; mdl_cs[0] = '0; mdl_cs[1] = '0;

        // Buffer contents survive reset.
        run(0, 4, 1'b0, 0, -1, -1, 0, 16'h0, "after_rst");

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 2; i++) load($urandom_range(0, DEPTH - 1), 16'($urandom));
            d    = $urandom_range(0, 1);
            plen = $urandom_range(0, 15);
            lp   = 1'($urandom_range(0, 1));
            nw   = $urandom_range(1, 12);
            if (lp) sk = nw - 1;
            else    sk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1;
            wi   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 6) : -1;
            run(d, plen, lp, nw, sk, wi, $urandom_range(0, DEPTH - 1), 16'($urandom),
                $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/minirisc_instr_streamer.md
Name: minirisc_instr_streamer

Overview:
- Drives the instruction/operand bus of the tt_um_minirisc core: ui_out feeds the core's ui_in, uio_out feeds its uio_in.
- Holds a small program buffer of 16-bit words (hi byte to ui_out, lo byte to uio_out) loaded through a write port.
- On start, issues one word per slot, with optional idle gaps, looping or stopping at program end.
- Used as the program source in place of hand-driven stimulus and as the bring-up sequencer on board.

Parameters:
- DEPTH, 8, program buffer entries (power of two, 2..64); AW = clog2(DEPTH).
- ISSUE_GAP, 0, idle cycles inserted after each issued word (0..15).
- NOP_WORD, 16'h0000, word driven on ui_out/uio_out whenever no instruction is valid.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  program buffer write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  16  word written; [15:8] to ui_out, [7:0] to uio_out.
- start  in  1  begin issuing from address 0.
- stop  in  1  abort issue.
- loop_en  in  1  wrap to address 0 at program end (sampled live).
- prog_len  in  AW+1  number of words to issue.
- result_in  in  8  core uo_out, sampled by the optional feature.
- ui_out  out  8  instruction hi byte to the core.
- uio_out  out  8  instruction lo byte to the core.
- instr_valid  out  1  high in each cycle a program word is on the bus.
- pc  out  AW  buffer index of the word currently on the bus.
- busy  out  1  high in ISSUE or GAP.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE; pc=0; len=0.
  - ui_out/uio_out = NOP_WORD; instr_valid=0; busy=0; done=0.
  - Buffer contents are not cleared.
- All outputs are registered.
- FSM states IDLE, ISSUE, GAP.
- IDLE:
  - Accepts start when prog_len != 0. prog_len > DEPTH is clamped to DEPTH. prog_len = 0 leaves the block in IDLE.
  - On accept: latch len, pc=0, go to ISSUE.
  - Latency: ui_out/uio_out show mem[0] with instr_valid=1 in the cycle after start is sampled.
- ISSUE:
  - Exactly one cycle per word: instr_valid=1, bus = mem[pc].
  - If ISSUE_GAP=0, the next word follows in the next cycle. Otherwise go to GAP.
- GAP:
  - Lasts ISSUE_GAP cycles; bus = NOP_WORD, instr_valid=0, busy=1.
- Advance from the word at pc:
  - pc < len-1: pc+1.
  - pc == len-1 with loop_en=1: pc wraps to 0 and issue continues.
  - pc == len-1 with loop_en=0: go to IDLE. done=1 for the one cycle after the last word (after its gap if ISSUE_GAP>0). Bus = NOP, busy=0 in that cycle.
- stop:
  - In ISSUE/GAP: go to IDLE at the next edge; bus = NOP, no done pulse, pc holds its last value.
  - stop and start in the same cycle: stop wins.
  - start while busy is ignored.
- Writes:
  - Allowed in any state; a write to an address >= DEPTH is ignored.
  - Same-cycle write and issue of the same address: old data is issued (read-before-write).
- rst mid-issue: immediate return to reset values at that edge, no done pulse.

Optional Feature:
- Macro: MINIRISC_STREAMER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[7:0].
  - Accumulates checksum <= checksum XOR result_in on every cycle instr_valid=1.
  - Cleared to 0 on reset and on each accepted start.
  - Holds its value in IDLE.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package minirisc_pkg:
  - FSM state enum (IDLE, ISSUE, GAP).
  - instr_word_t (16-bit).
  - NOP default constant.
- One natural sub-module: minirisc_prog_ram (DEPTH x 16 storage, synchronous write, read-before-write, registered read used by the issue path).

Test Plan:
- Load mem[0..3] = 0101, 0202, 0303, 0404; prog_len=4, loop_en=0, ISSUE_GAP=0; pulse start -> ui_out/uio_out = 01/01, 02/02, 03/03, 04/04 on consecutive cycles starting one cycle after start; pc 0..3; done pulses the next cycle; bus returns to 00/00.
- Same program, loop_en=1 -> sequence 01,02,03,04,01,02… with no done pulse; assert stop during word 03 -> next cycle bus 00/00, busy=0, done=0.
- ISSUE_GAP=2, prog_len=2 -> valid, NOP, NOP, valid, NOP, NOP, then done; instr_valid duty 1 of 3 cycles.
- prog_len=0 with start -> stays IDLE, busy=0. prog_len=9 with DEPTH=8 -> issues 8 words, then done.
- During the run, write mem[2]=AAAA in the same cycle pc=2 is issued -> old 0303 appears; next loop pass shows AA/AA. Assert rst mid-run -> all outputs at reset values after that edge.
- With MINIRISC_STREAMER_CHECKSUM_EN: result_in = 11, 22, 33, 44 on the four valid cycles -> checksum = 44. A new start clears it to 00.
